req_capture_12b: RTL

Input-conditioning stage that sits directly upstream of the 12-bit priority encoder. It synchronises and debounces 12 raw request lines, such as push-buttons or switches, and turns each debounced rising edge into a sticky pending bit. The pending vector drives the encoder's `req` input. The consumer clears one pending bit at a time by index, which is normally the encoder's 4-bit output fed back with a valid strobe.

---
 rtl/req_capture_12b_if.sv | 42 ++++
 rtl/req_capture_12b.sv | 91 +++++++++
 2 files changed

// File: rtl/req_capture_12b_if.sv
// ----------------------------------------------------------------------------
// req_capture_12b_if
// Bundles the request-conditioning stage's data and clear-handshake signals.
//
// Signals:
//   raw_in    [11:0]  asynchronous request lines (bit i = channel i)
//   clr_valid         single-cycle strobe that clears one pending bit
//   clr_idx   [3:0]   index of the pending bit to clear (12..15 ignored)
//   req       [11:0]  sticky pending vector, feeds the priority encoder
//   db_level  [11:0]  debounced level of each channel
//   any_req           OR of req, registered alongside req
//
// Modports:
//   master - the environment: drives raw_in/clr_*, observes the outputs
//   slave  - the capture block itself
// ----------------------------------------------------------------------------
interface req_capture_12b_if;
    logic [11:0] raw_in;
    logic        clr_valid;
    logic [3:0]  clr_idx;
    logic [11:0] req;
    logic [11:0] db_level;
    logic        any_req;

    modport master (
        output raw_in,
        output clr_valid,
        output clr_idx,
        input  req,
        input  db_level,
        input  any_req
    );

    modport slave (
        input  raw_in,
        input  clr_valid,
        input  clr_idx,
        output req,
        output db_level,
        output any_req
    );
endinterface

// File: rtl/req_capture_12b.sv
// ----------------------------------------------------------------------------
// req_capture_12b
// Input-conditioning stage in front of the 12-bit priority encoder. Each of
// the 12 raw request lines is synchronised (two flops), debounced by a
// per-channel counter, and every debounced rising edge sets a sticky pending
// bit. The consumer retires one pending bit at a time by index.
//
// Ports:
//   clk    - single clock, all state updates on its rising edge
//   rst_n  - synchronous reset, active low
//   bus    - req_capture_12b_if.slave (raw_in, clr_valid, clr_idx in;
//            req, db_level, any_req out)
//
// Parameter:
//   DB_COUNT - consecutive cycles the synchronised input must differ from the
//              debounced level before that level flips (>= 1)
// ----------------------------------------------------------------------------
module req_capture_12b #(
    parameter int DB_COUNT = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    req_capture_12b_if.slave   bus
);

    localparam int CW = $clog2(DB_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

    logic [11:0]   r_sync1;
    logic [11:0]   r_sync2;
    logic [CW-1:0] r_cnt [12];
    logic [11:0]   r_dbLevel;
    logic [11:0]   r_req;
    logic          r_anyReq;

    logic [11:0]   w_differs;
    logic [11:0]   w_flip;
    logic [11:0]   w_rise;
    logic [11:0]   w_clrHit;
    logic [11:0]   w_reqNext;

    // A channel flips once it has disagreed with the debounced level for
    // DB_COUNT consecutive samples; only flips towards 1 count as a press.
    // Indices 12..15 match no channel, so the encoder's "none" code is inert.
    // The set term is ORed in last so a press coinciding with a clear of the
    // same bit is never lost.
    always_comb begin
        w_differs = r_sync2 ^ r_dbLevel;
        w_flip    = '0;
        w_clrHit  = '0;
        for (int i = 0; i < 12; i++) begin
            w_flip[i]   = w_differs[i] && (r_cnt[i] == CNT_LAST);
            w_clrHit[i] = bus.clr_valid && (bus.clr_idx == 4'(i));
        end
        w_rise    = w_flip & r_sync2;
        w_reqNext = (r_req & ~w_clrHit) | w_rise;
    end

    // Synchroniser, debounce counters, debounced level and pending vector.
    // any_req is computed from the next req value so both change together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_dbLevel <= '0;
            r_req     <= '0;
            r_anyReq  <= 1'b0;
            for (int i = 0; i < 12; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= bus.raw_in;
            r_sync2   <= r_sync1;
            r_dbLevel <= r_dbLevel ^ w_flip;
            r_req     <= w_reqNext;
            r_anyReq  <= |w_reqNext;
            for (int i = 0; i < 12; i++) begin
                if (!w_differs[i] || w_flip[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.req      = r_req;
    assign bus.db_level = r_dbLevel;
    assign bus.any_req  = r_anyReq;

endmodule
